// File: rtl/stage_sequencer_if.sv
// Request/status bundle between a run requester and stage_sequencer.
// master: the requester side. slave: the sequencer.
interface stage_sequencer_if #(
  parameter int INTERVAL_W = 4
);
  logic                  req_valid;
  logic [INTERVAL_W-1:0] req_interval;
  logic                  req_ready;
  logic                  start;
  logic                  shift;
  logic                  done;
  logic                  busy;
  logic [3:0]            stage_idx;

  modport master (
    output req_valid, req_interval,
    input  req_ready, start, shift, done, busy, stage_idx
  );

  modport slave (
    input  req_valid, req_interval,
    output req_ready, start, shift, done, busy, stage_idx
  );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: on an accepted request, emits one start pulse, then
// NUM_STAGES shift pulses spaced req_interval+1 cycles apart, then a done
// pulse. The wait between shifts is a down-counter loaded from the latched
// interval.
// Optional feature: define STAGE_SEQ_ABORT_EN to add an abort input that
// drops any active run back to IDLE and an aborted status pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request; req_ready high
// S_START | start pulse; stage index cleared, wait counter loaded
// S_WAIT  | counting down the idle gap before the next shift
// S_SHIFT | shift pulse; stage index advances
// S_DONE  | done pulse after the final shift
module stage_sequencer #(
  parameter int NUM_STAGES = 6,
  parameter int INTERVAL_W = 4
) (
  input  logic clk,
  input  logic rst,
  stage_sequencer_if.slave bus
`ifdef STAGE_SEQ_ABORT_EN
  ,
  input  logic abort,
  output logic aborted
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0]            LAST_IDX = 4'(NUM_STAGES);
  localparam logic [INTERVAL_W-1:0] CNT_ONE  = INTERVAL_W'(1);

  state_t                state_q, state_d;
  logic [INTERVAL_W-1:0] cnt_q, cnt_d;
  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic [3:0]            stage_idx_q, stage_idx_d;

  logic accept;
  logic last_shift;
  logic interval_zero;
  logic abort_hit;

  assign accept        = (state_q == S_IDLE) && bus.req_valid;
  assign last_shift    = (stage_idx_q + 4'd1) == LAST_IDX;
  assign interval_zero = (interval_q == '0);

`ifdef STAGE_SEQ_ABORT_EN
  logic aborted_q, aborted_d;

  // abort only matters while a run is in progress
  assign abort_hit = abort && (state_q != S_IDLE);
  assign aborted_d = abort_hit;
  assign aborted   = aborted_q;

  // aborted status pulse, one cycle after the abort edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end
`else
  assign abort_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = interval_zero ? S_SHIFT : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_shift) begin
          state_d = S_DONE;
        end else begin
          state_d = interval_zero ? S_SHIFT : S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
    end
  end

  // counter, latched interval and stage index registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      interval_q  <= '0;
      stage_idx_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      interval_q  <= interval_d;
      stage_idx_q <= stage_idx_d;
    end
  end

  // datapath updates; the interval is captured only on acceptance so a
  // changing req_interval cannot disturb a run in progress
  always_comb begin
    cnt_d       = cnt_q;
    interval_d  = interval_q;
    stage_idx_d = stage_idx_q;
    if (accept) begin
      interval_d = bus.req_interval;
    end
    case (state_q)
      S_START: begin
        cnt_d       = interval_q;
        stage_idx_d = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
      end
      S_SHIFT: begin
        cnt_d       = interval_q;
        stage_idx_d = stage_idx_q + 4'd1;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
    // an aborted run keeps the stage count it reached
    if (abort_hit) begin
      cnt_d       = '0;
      stage_idx_d = stage_idx_q;
    end
  end

  // outputs decoded from the registered state only
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.start     = (state_q == S_START);
    bus.shift     = (state_q == S_SHIFT);
    bus.done      = (state_q == S_DONE);
    bus.stage_idx = stage_idx_q;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 6, number of shift pulses per run; matches the 6-bit stage clock chain fed by this block; legal 1..15.
REQ-002 Parameter INTERVAL_W, default 4, width of the shift-interval field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  run request.
REQ-006 req_interval  input  INTERVAL_W  idle cycles between consecutive shift pulses; sampled on acceptance.
REQ-007 req_ready  output  1  high only in IDLE.
REQ-008 start  output  1  one-cycle pulse that launches the downstream stage chain.
REQ-009 shift  output  1  one-cycle pulse that advances the downstream stage chain.
REQ-010 done  output  1  one-cycle pulse after the final shift.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 stage_idx  output  4  number of shift pulses issued in the current run; holds its final value until the next start.

Function
REQ-013 States: IDLE, START, WAIT, SHIFT, DONE; outputs are decoded from the registered state only, with no combinational path from inputs.
REQ-014 IDLE: a request is accepted when req_valid and req_ready are both high at a clock edge; req_interval is latched into interval_q; next state START.
REQ-015 START: start=1 for exactly one cycle; stage_idx cleared to 0; wait counter loaded with interval_q; next state SHIFT if interval_q==0, else WAIT.
REQ-016 WAIT: counter decrements each cycle; transition to SHIFT on the cycle the counter reaches 1; the block spends exactly interval_q cycles in WAIT.
REQ-017 SHIFT: shift=1 for one cycle; stage_idx increments; if the new stage_idx==NUM_STAGES, next state DONE; otherwise reload the counter and go to WAIT, or repeat SHIFT when interval_q==0.
REQ-018 DONE: done=1 for one cycle; next state IDLE; req_ready is high on the following cycle.
REQ-019 Shift pulses are spaced interval_q+1 cycles apart; the first shift follows start by interval_q+1 cycles.
REQ-020 With acceptance at edge 0, a run occupies 2+NUM_STAGES*(interval_q+1) busy cycles.
REQ-021 req_valid is ignored outside IDLE; requests are never queued.
REQ-022 Changes to req_interval during a run have no effect on that run.
REQ-023 start, shift and done are mutually exclusive in every cycle.

Reset
REQ-024 rst low forces, asynchronously: state=IDLE, counter=0, interval_q=0, stage_idx=0.
REQ-025 While rst is low: start=shift=done=busy=0, req_ready=1, and no request is accepted.
REQ-026 Reset mid-run abandons the run; no done pulse is produced.
REQ-027 After rst rises, the first rising clock edge may accept a request.

Configuration
REQ-028 Macro STAGE_SEQ_ABORT_EN.
- Defined: adds input abort (1 bit) and output aborted (1 bit). abort high at an edge in any non-IDLE state forces IDLE on that edge. aborted pulses for one cycle on the next cycle. No further start, shift or done is issued for that run. stage_idx holds its value. abort is ignored in IDLE.
- Undefined: neither port exists, and a run always completes.

Verification
REQ-029 Reset release, then req_valid=1 with req_interval=0: start in cycle 1, shift in cycles 2-7, done in cycle 8, req_ready=1 in cycle 9, stage_idx=6.
REQ-030 req_interval=2: start in cycle 1, shifts in cycles 4, 7, 10, 13, 16, 19, done in cycle 20, busy high in cycles 1-20.
REQ-031 req_valid held high throughout two runs with interval=0: second start in cycle 10, with no request accepted during cycles 1-8.
REQ-032 rst pulled low in cycle 5 of an interval=0 run: busy=0 and req_ready=1 immediately, no done pulse, stage_idx=0.
REQ-033 STAGE_SEQ_ABORT_EN defined, interval=1, abort asserted in cycle 6: no start, shift or done from cycle 6 onward for that run, aborted=1 in cycle 7, req_ready=1 in cycle 7.
